// File: rtl/sram_sp_fifo_ctrl.sv
// ============================================================================
// Module   : sram_sp_fifo_ctrl
// Brief    : Streaming FIFO controller over one single-port SRAM macro, with
//            fair read/write port arbitration and a 2-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_sp_fifo_ctrl #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 2048
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DATA_WIDTH-1:0]  IN_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DATA_WIDTH-1:0]  OUT_DATA,
  output logic [ADDR_BITS+1:0]   COUNT,
  output logic                   SRAM_ME,
  output logic                   SRAM_WE,
  output logic [ADDR_BITS-1:0]   SRAM_ADR,
  output logic [DATA_WIDTH-1:0]  SRAM_D,
  input  logic [DATA_WIDTH-1:0]  SRAM_Q
);

  localparam logic [ADDR_BITS:0]   c_depth   = (ADDR_BITS+1)'(MEM_DEPTH);
  localparam logic [ADDR_BITS-1:0] c_ptr_one = (ADDR_BITS)'(1);
  localparam logic [ADDR_BITS:0]   c_cnt_one = (ADDR_BITS+1)'(1);

  logic [ADDR_BITS-1:0]  r_wr_ptr;
  logic [ADDR_BITS-1:0]  r_rd_ptr;
  logic [ADDR_BITS:0]    r_sram_cnt;
  logic [1:0]            r_ob_cnt;
  logic                  r_rd_inflight;
  logic                  r_arb_last;
  logic [DATA_WIDTH-1:0] r_ob_head;
  logic [DATA_WIDTH-1:0] r_ob_tail;

  logic w_full;
  logic w_rd_want;
  logic w_wr_want;
  logic w_rd_gnt;
  logic w_wr_gnt;
  logic w_contested;
  logic w_pop;
  logic w_cap;

  // A read may only launch if the buffer has room for it once it lands.
  assign w_full      = (r_sram_cnt == c_depth);
  assign w_rd_want   = (r_sram_cnt != '0) &&
                       (({1'b0, r_ob_cnt} + {2'b00, r_rd_inflight}) < 3'd2);
  assign w_wr_want   = RST_N && IN_VALID && !w_full;
  assign w_contested = w_rd_want && w_wr_want;
  assign w_rd_gnt    = w_rd_want && (!w_wr_want || !r_arb_last);
  assign w_wr_gnt    = w_wr_want && !w_rd_gnt;
  assign w_pop       = (r_ob_cnt != 2'd0) && OUT_READY;
  assign w_cap       = r_rd_inflight;

  assign IN_READY  = !w_full && !w_rd_gnt;
  assign OUT_VALID = (r_ob_cnt != 2'd0);
  assign OUT_DATA  = r_ob_head;
  assign COUNT     = {1'b0, r_sram_cnt} + (ADDR_BITS+2)'(r_ob_cnt)
                   + (ADDR_BITS+2)'(r_rd_inflight);

  assign SRAM_ME  = w_rd_gnt || w_wr_gnt;
  assign SRAM_WE  = w_wr_gnt;
  assign SRAM_ADR = w_rd_gnt ? r_rd_ptr : (w_wr_gnt ? r_wr_ptr : '0);
  assign SRAM_D   = w_wr_gnt ? IN_DATA : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_sram_cnt    <= '0;
      r_ob_cnt      <= 2'd0;
      r_rd_inflight <= 1'b0;
      r_arb_last    <= 1'b0;
    end else begin
      if (w_wr_gnt) begin
        r_wr_ptr   <= r_wr_ptr + c_ptr_one;
        r_sram_cnt <= r_sram_cnt + c_cnt_one;
      end else if (w_rd_gnt) begin
        r_rd_ptr   <= r_rd_ptr + c_ptr_one;
        r_sram_cnt <= r_sram_cnt - c_cnt_one;
      end
      r_rd_inflight <= w_rd_gnt;
      if (w_contested) begin
        r_arb_last <= w_rd_gnt;
      end
      r_ob_cnt <= r_ob_cnt + {1'b0, w_cap} - {1'b0, w_pop};
    end
  end

  // Head is always a register so OUT_DATA never sees SRAM_Q combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ob_head <= '0;
      r_ob_tail <= '0;
    end else if (w_pop) begin
      if (w_cap && (r_ob_cnt == 2'd1)) begin
        r_ob_head <= SRAM_Q;
      end else begin
        r_ob_head <= r_ob_tail;
      end
      if (w_cap && (r_ob_cnt == 2'd2)) begin
        r_ob_tail <= SRAM_Q;
      end
    end else if (w_cap) begin
      if (r_ob_cnt == 2'd0) begin
        r_ob_head <= SRAM_Q;
      end else begin
        r_ob_tail <= SRAM_Q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_sp_fifo_ctrl.sv
// ============================================================================
// Module   : tb_sram_sp_fifo_ctrl
// Brief    : Self-checking bench for sram_sp_fifo_ctrl with an SRAM model and
//            a queue-based reference of the FIFO contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_sp_fifo_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int DEPTH = 2048;
  localparam int CAP   = DEPTH + 2;

  logic          CLK       = 1'b0;
  logic          RST_N     = 1'b0;
  logic          IN_VALID  = 1'b0;
  logic [DW-1:0] IN_DATA   = '0;
  logic          OUT_READY = 1'b0;
  logic          IN_READY;
  logic          OUT_VALID;
  logic [DW-1:0] OUT_DATA;
  logic [AW+1:0] COUNT;
  logic          SRAM_ME;
  logic          SRAM_WE;
  logic [AW-1:0] SRAM_ADR;
  logic [DW-1:0] SRAM_D;
  logic [DW-1:0] SRAM_Q = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] q[$];

  sram_sp_fifo_ctrl #(.ADDR_BITS(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .COUNT(COUNT),
    .SRAM_ME(SRAM_ME), .SRAM_WE(SRAM_WE), .SRAM_ADR(SRAM_ADR),
    .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  always #5 CLK = ~CLK;

  // Single-port SRAM: one access per edge, read data valid the next cycle.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (SRAM_ME) begin
      if (SRAM_WE) mem[SRAM_ADR] <= SRAM_D;
      else         SRAM_Q <= mem[SRAM_ADR];
    end
  end

  // Access monitor: writes and reads must each walk addresses 0,1,2,... mod DEPTH.
  int            addr_err = 0;
  int            n_wr = 0;
  int            n_rd = 0;
  bit            wr_wrap = 1'b0;
  bit            rd_wrap = 1'b0;
  logic [AW-1:0] exp_wa = '0;
  logic [AW-1:0] exp_ra = '0;
  always @(negedge CLK) begin
    #2;
    if (!RST_N) begin
      addr_err = 0; n_wr = 0; n_rd = 0; wr_wrap = 1'b0; rd_wrap = 1'b0;
      exp_wa = '0; exp_ra = '0;
    end else if (SRAM_ME) begin
      if (SRAM_WE) begin
        if (SRAM_ADR !== exp_wa) addr_err++;
        if (exp_wa == '0 && n_wr > 0) wr_wrap = 1'b1;
        exp_wa = exp_wa + 1'b1;
        n_wr++;
      end else begin
        if (SRAM_ADR !== exp_ra) addr_err++;
        if (exp_ra == '0 && n_rd > 0) rd_wrap = 1'b1;
        exp_ra = exp_ra + 1'b1;
        n_rd++;
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    @(negedge CLK);
    IN_VALID = v; IN_DATA = d; OUT_READY = r;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    q.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_N = 1'b0; IN_VALID = 1'b1; IN_DATA = 64'hDEAD_BEEF_0123_4567; OUT_READY = 1'b1;
    #1;
    n_checks++; if (SRAM_ME !== 1'b0) begin n_fail++; $display("FAIL rst_me: got %b expected 0", SRAM_ME); end
    n_checks++; if (SRAM_WE !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", SRAM_WE); end
    n_checks++; if (SRAM_ADR !== '0) begin n_fail++; $display("FAIL rst_adr: got %h expected 0", SRAM_ADR); end
    n_checks++; if (SRAM_D !== '0) begin n_fail++; $display("FAIL rst_d: got %h expected 0", SRAM_D); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_ovalid: got %b expected 0", OUT_VALID); end
    @(negedge CLK);
    IN_VALID = 1'b0; RST_N = 1'b1;
    q.delete();
    #1;
    n_checks++; if (COUNT !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", COUNT); end
    n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_iready: got %b expected 1", IN_READY); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_ovalid2: got %b expected 0", OUT_VALID); end
  endtask

  task automatic test_latency();
    apply_reset();
    drive(1'b1, 64'h1111, 1'b1);
    n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL lat_iready: got %b expected 1", IN_READY); end
    n_checks++; if ({SRAM_ME, SRAM_WE} !== 2'b11 || SRAM_ADR !== '0 || SRAM_D !== 64'h1111)
      begin n_fail++; $display("FAIL lat_write: got me/we=%b%b adr=%h d=%h expected 11 0 1111", SRAM_ME, SRAM_WE, SRAM_ADR, SRAM_D); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (COUNT !== 13'd1) begin n_fail++; $display("FAIL lat_count0: got %0d expected 1", COUNT); end
    n_checks++; if ({SRAM_ME, SRAM_WE} !== 2'b10 || SRAM_ADR !== '0)
      begin n_fail++; $display("FAIL lat_read: got me/we=%b%b adr=%h expected 10 0", SRAM_ME, SRAM_WE, SRAM_ADR); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (COUNT !== 13'd1 || OUT_VALID !== 1'b0)
      begin n_fail++; $display("FAIL lat_inflight: got count=%0d ovalid=%b expected 1 0", COUNT, OUT_VALID); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 64'h1111 || COUNT !== 13'd1)
      begin n_fail++; $display("FAIL lat_out: got ovalid=%b data=%h count=%0d expected 1 1111 1", OUT_VALID, OUT_DATA, COUNT); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (COUNT !== '0 || OUT_VALID !== 1'b0)
      begin n_fail++; $display("FAIL lat_pop: got count=%0d ovalid=%b expected 0 0", COUNT, OUT_VALID); end
  endtask

  task automatic test_fill_drain();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    apply_reset();
    while (sent < CAP && cyc < 6000) begin
      drive(1'b1, DW'(sent), 1'b0);
      if (IN_READY) sent++;
      cyc++;
    end
    n_checks++; if (sent != CAP) begin n_fail++; $display("FAIL fill_sent: got %0d expected %0d", sent, CAP); end
    drive(1'b1, 64'hFFFF, 1'b0);
    n_checks++; if (COUNT !== 13'(CAP)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", COUNT, CAP); end
    n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL fill_iready: got %b expected 0", IN_READY); end
    n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== '0)
      begin n_fail++; $display("FAIL fill_head: got ovalid=%b data=%h expected 1 0", OUT_VALID, OUT_DATA); end
    n_checks++; if (SRAM_ME !== 1'b0) begin n_fail++; $display("FAIL full_me: got %b expected 0", SRAM_ME); end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (SRAM_ME !== 1'b0) begin n_fail++; $display("FAIL ob_full_me: got %b expected 0", SRAM_ME); end
    cyc = 0;
    while (got < CAP && cyc < 8000) begin
      drive(1'b0, '0, 1'b1);
      if (OUT_VALID) begin
        n_checks++; if (OUT_DATA !== DW'(got)) begin n_fail++; $display("FAIL drain_data: got %h expected %h", OUT_DATA, DW'(got)); end
        got++;
      end
      cyc++;
    end
    n_checks++; if (got != CAP) begin n_fail++; $display("FAIL drain_cnt: got %0d expected %0d", got, CAP); end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (COUNT !== '0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", COUNT); end
    n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL fill_addr: got %0d errors expected 0", addr_err); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int pushes = 0;
    int pops = 0;
    logic [DW-1:0] d;
    apply_reset();
    while (q.size() < 4 && cyc < 50) begin
      d = {$urandom, $urandom};
      drive(1'b1, d, 1'b0);
      if (IN_READY) q.push_back(d);
      cyc++;
    end
    for (int i = 0; i < 100; i++) begin
      d = {$urandom, $urandom};
      drive(1'b1, d, 1'b1);
      n_checks++; if (int'(COUNT) != q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", COUNT, q.size()); end
      if (OUT_VALID) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL b2b_spurious: got data %h expected none", OUT_DATA); end
        else begin
          if (OUT_DATA !== q[0]) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", OUT_DATA, q[0]); end
          void'(q.pop_front());
          pops++;
        end
      end
      if (IN_READY) begin q.push_back(d); pushes++; end
    end
    n_checks++; if (pushes < 40) begin n_fail++; $display("FAIL b2b_pushes: got %0d expected >=40", pushes); end
    n_checks++; if (pops < 40) begin n_fail++; $display("FAIL b2b_pops: got %0d expected >=40", pops); end
    cyc = 0;
    while (q.size() > 0 && cyc < 500) begin
      drive(1'b0, '0, 1'b1);
      if (OUT_VALID) begin
        n_checks++; if (OUT_DATA !== q[0]) begin n_fail++; $display("FAIL b2b_tail: got %h expected %h", OUT_DATA, q[0]); end
        void'(q.pop_front());
      end
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (COUNT !== '0 || q.size() != 0)
      begin n_fail++; $display("FAIL b2b_empty: got count=%0d left=%0d expected 0 0", COUNT, q.size()); end
    n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL b2b_addr: got %0d errors expected 0", addr_err); end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    bit v;
    bit r;
    logic [DW-1:0] d;
    apply_reset();
    while (q.size() < DEPTH - 1 && cyc < 6000) begin
      d = {$urandom, $urandom};
      drive(1'b1, d, 1'b0);
      if (IN_READY) q.push_back(d);
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (COUNT !== 13'(DEPTH - 1)) begin n_fail++; $display("FAIL wrap_prefill: got %0d expected %0d", COUNT, DEPTH - 1); end
    cyc = 0;
    while (cyc < 8000 || (q.size() > 0 && cyc < 18000)) begin
      v = (cyc < 8000) && ($urandom_range(0, 3) == 0);
      r = (cyc >= 8000) || ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom};
      drive(v, d, r);
      n_checks++; if (int'(COUNT) != q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", COUNT, q.size()); end
      if (OUT_VALID && r) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL wrap_spurious: got data %h expected none", OUT_DATA); end
        else begin
          if (OUT_DATA !== q[0]) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", OUT_DATA, q[0]); end
          void'(q.pop_front());
        end
      end
      if (v && IN_READY) q.push_back(d);
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (COUNT !== '0 || q.size() != 0)
      begin n_fail++; $display("FAIL wrap_empty: got count=%0d left=%0d expected 0 0", COUNT, q.size()); end
    n_checks++; if (wr_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_wr: got %b expected 1", wr_wrap); end
    n_checks++; if (rd_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_rd: got %b expected 1", rd_wrap); end
    n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL wrap_addr: got %0d errors expected 0", addr_err); end
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    logic [DW-1:0] d;
    apply_reset();
    while (q.size() < 3 && cyc < 20) begin
      d = {$urandom, $urandom};
      drive(1'b1, d, 1'b0);
      if (IN_READY) q.push_back(d);
      cyc++;
    end
    drive(1'b1, 64'h5555, 1'b0);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    q.delete();
    #1;
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL arst_ovalid: got %b expected 0", OUT_VALID); end
    n_checks++; if (COUNT !== '0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", COUNT); end
    n_checks++; if (SRAM_ME !== 1'b0) begin n_fail++; $display("FAIL arst_me: got %b expected 0", SRAM_ME); end
    repeat (2) @(negedge CLK);
    IN_VALID = 1'b0;
    RST_N = 1'b1;
    drive(1'b1, 64'hABCD, 1'b1);
    n_checks++; if ({SRAM_ME, SRAM_WE} !== 2'b11 || SRAM_ADR !== '0 || IN_READY !== 1'b1)
      begin n_fail++; $display("FAIL arst_wr: got me/we=%b%b adr=%h ready=%b expected 11 0 1", SRAM_ME, SRAM_WE, SRAM_ADR, IN_READY); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if ({SRAM_ME, SRAM_WE} !== 2'b10 || SRAM_ADR !== '0)
      begin n_fail++; $display("FAIL arst_rd: got me/we=%b%b adr=%h expected 10 0", SRAM_ME, SRAM_WE, SRAM_ADR); end
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 64'hABCD)
      begin n_fail++; $display("FAIL arst_out: got ovalid=%b data=%h expected 1 abcd", OUT_VALID, OUT_DATA); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_drain();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
